// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared definitions for the seven-segment scan controller.
//   state_t    : scan FSM states (IDLE, BLANK, SHOW)
//   SEG_OFF    : all segments unlit, active-high gfedcba
//   hex_decode : nibble -> active-high gfedcba segment pattern
package sevenseg_pkg;
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction
endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// sevenseg_scan_ctrl_if: bundle between the value producer, the scan controller and the display pins.
//   enable, value, dp, load      : producer -> controller
//   seg, dp_out, an, frame_done  : controller -> display pins / producer
//   master: producer side, slave: controller side
interface sevenseg_scan_ctrl_if #(parameter int DIGITS = 4);
    logic                  enable;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp;
    logic                  load;
    logic [6:0]            seg;
    logic                  dp_out;
    logic [DIGITS-1:0]     an;
    logic                  frame_done;
    modport master (output enable, value, dp, load, input seg, dp_out, an, frame_done);
    modport slave  (input enable, value, dp, load, output seg, dp_out, an, frame_done);
endinterface

// File: rtl/scan_slot_timer.sv
// scan_slot_timer: up-counting slot timer; done is high on the last cycle of a slot.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the count at 0 on the next edge
//   limit    : slot length minus one
//   done     : high while the count has reached limit
module scan_slot_timer #(parameter int WIDTH = 4) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] limit,
    output logic             done
);
    logic [WIDTH-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (cnt != limit) cnt <= cnt + 1'b1;
    end
    assign done = cnt == limit;
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: multiplexed seven-segment scan controller with blanking and double-buffered value.
//   clk, rst   : clock, synchronous active-high reset
//   bus.enable : scan run, display dark when low
//   bus.value  : packed hex nibbles, bus.dp : per-digit decimal points, bus.load : capture strobe
//   bus.seg    : segments a..g on bits 0..6, bus.dp_out : decimal point, bus.an : digit enables
//   bus.frame_done : one-cycle pulse when the last digit's slot ends
//   Optional macro SEVENSEG_LZB_EN enables leading-zero blanking.
module sevenseg_scan_ctrl import sevenseg_pkg::*; #(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1,
    parameter bit AN_ACTIVE_LOW  = 1
) (
    input  logic                clk,
    input  logic                rst,
    sevenseg_scan_ctrl_if.slave bus
);
    localparam int TW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [TW-1:0] BLANK_LIM = TW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
    localparam logic [TW-1:0] SHOW_LIM = TW'(PRESCALE - BLANK_CYCLES - 1);
    localparam logic [DW-1:0] LAST = DW'(DIGITS - 1);
    localparam state_t SLOT_START = BLANK_CYCLES > 0 ? BLANK : SHOW;
    localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{AN_ACTIVE_LOW}};
    localparam logic [6:0] SEG_IDLE = SEG_OFF ^ {7{SEG_ACTIVE_LOW}};

    state_t              state, state_n;
    logic [DW-1:0]       digit, digit_n;
    logic [4*DIGITS-1:0] shadow_val, disp_val, disp_val_n;
    logic [DIGITS-1:0]   shadow_dp, disp_dp, disp_dp_n;
    logic                pending, done, wrap, upd_win, load_now, seg_blank;
    logic [3:0]          nib;
    logic [6:0]          seg_raw;

    scan_slot_timer #(.WIDTH(TW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == IDLE || !bus.enable || done),
        .limit (state == BLANK ? BLANK_LIM : SHOW_LIM),
        .done  (done)
    );

    always_comb begin
        wrap = bus.enable && state == SHOW && done && digit == LAST;
        // The display may change before any digit of a frame is shown: on the wrap edge,
        // throughout digit 0's blank, and on the edge leaving IDLE.
        upd_win = bus.enable && (state == IDLE || wrap || (state == BLANK && digit == '0));
        load_now = bus.load && (state == IDLE || upd_win);
        disp_val_n = load_now ? bus.value : pending && upd_win ? shadow_val : disp_val;
        disp_dp_n = load_now ? bus.dp : pending && upd_win ? shadow_dp : disp_dp;
        state_n = state;
        digit_n = digit;
        if (!bus.enable) begin
            state_n = IDLE;
            digit_n = '0;
        end else if (state == IDLE) begin
            state_n = SLOT_START;
        end else if (done) begin
            state_n = state == BLANK ? SHOW : SLOT_START;
            digit_n = state == BLANK ? digit : digit == LAST ? '0 : digit + 1'b1;
        end
        nib = 4'(disp_val_n >> {digit_n, 2'b00});
`ifdef SEVENSEG_LZB_EN
        seg_blank = digit_n != '0 && (disp_val_n >> {digit_n, 2'b00}) == '0;
`else
        seg_blank = 1'b0;
`endif
        seg_raw = seg_blank ? SEG_OFF : hex_decode(nib);
    end

    // Outputs are computed from the next state so they change on the edge the FSM enters it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            digit <= '0;
            shadow_val <= '0;
            shadow_dp <= '0;
            disp_val <= '0;
            disp_dp <= '0;
            pending <= 1'b0;
            bus.an <= AN_OFF;
            bus.seg <= SEG_IDLE;
            bus.dp_out <= SEG_ACTIVE_LOW;
            bus.frame_done <= 1'b0;
        end else begin
            state <= state_n;
            digit <= digit_n;
            disp_val <= disp_val_n;
            disp_dp <= disp_dp_n;
            if (bus.load) begin
                shadow_val <= bus.value;
                shadow_dp <= bus.dp;
            end
            pending <= bus.load ? !load_now : pending && !upd_win;
            bus.an <= (state_n == SHOW ? DIGITS'(1) << digit_n : '0) ^ AN_OFF;
            bus.seg <= (state_n == SHOW ? seg_raw : SEG_OFF) ^ {7{SEG_ACTIVE_LOW}};
            bus.dp_out <= (state_n == SHOW && disp_dp_n[digit_n]) ^ SEG_ACTIVE_LOW;
            bus.frame_done <= wrap;
        end
    end
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: directed bench for sevenseg_scan_ctrl with an expected-slot scoreboard.
module tb_sevenseg_scan_ctrl;
    localparam int DIGITS = 4;
    localparam int PRESCALE = 8;
    localparam int BLANK_CYCLES = 2;
    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } slot_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fd_count = 0;
    int fd_last = -1;
    int fd_period = 0;
    int fd_snap;
    slot_t exp_q[$];

    sevenseg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

    sevenseg_scan_ctrl #(
        .DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK_CYCLES),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (bus.frame_done === 1'b1) begin
            if (fd_last >= 0) fd_period = cyc - fd_last;
            fd_last = cyc;
            fd_count++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic slot_t exp_slot(input logic [15:0] v, input logic [3:0] p, input int d);
        slot_t s;
        logic [15:0] hi;
        hi = v >> (4 * d);
        s.an = ~(4'b0001 << d);
        s.seg = ~HEX[hi[3:0]];
`ifdef SEVENSEG_LZB_EN
        if (d > 0 && hi == 16'h0000) s.seg = 7'h7F;
`endif
        s.dp = ~p[d];
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] v, input logic [3:0] p);
        for (int d = 0; d < DIGITS; d++) exp_q.push_back(exp_slot(v, p, d));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] p);
        bus.value = v;
        bus.dp = p;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    // Waits for the next lit digit, compares it with the scoreboard head, then measures its length.
    task automatic check_slot(input int exp_wait);
        int w = 0;
        int n = 1;
        bit seen = 1'b0;
        slot_t e;
        while (bus.an === 4'hF && w < 60) begin
            @(negedge clk);
            w++;
        end
        checks++;
        assert (bus.an !== 4'hF) seen = 1'b1; else begin
            failures++;
            $error("FAIL slot_timeout observed an=%0h expected a lit digit", bus.an);
        end
        if (!seen) return;
        if (exp_wait >= 0) check("blank_cycles", w, exp_wait);
        e = exp_q.pop_front();
        check("an", bus.an, e.an);
        check("seg", bus.seg, e.seg);
        check("dp_out", bus.dp_out, e.dp);
        while (n < 60) begin
            @(negedge clk);
            if (bus.an !== e.an) break;
            n++;
        end
        check("show_cycles", n, PRESCALE - BLANK_CYCLES);
    endtask

    initial begin
        bus.enable = 1'b1;
        bus.load = 1'b1;
        bus.value = 16'hFFFF;
        bus.dp = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_an", bus.an, 4'hF);
        check("rst_seg", bus.seg, 7'h7F);
        check("rst_dp_out", bus.dp_out, 1'b1);
        check("rst_frame_done", bus.frame_done, 1'b0);
        rst = 1'b0;
        bus.load = 1'b0;
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);
        // Display must still hold zero: the load during reset is ignored.
        bus.enable = 1'b1;
        push_frame(16'h0000, 4'h0);
        check_slot(1 + BLANK_CYCLES);
        repeat (3) check_slot(BLANK_CYCLES);
        bus.enable = 1'b0;
        @(negedge clk);
        do_load(16'h12AF, 4'b0010);
        bus.enable = 1'b1;
        push_frame(16'h12AF, 4'b0010);
        check_slot(1 + BLANK_CYCLES);
        repeat (3) check_slot(BLANK_CYCLES);
        push_frame(16'h12AF, 4'b0010);
        repeat (4) check_slot(BLANK_CYCLES);
        check("frame_done_at_wrap", bus.frame_done, 1'b1);
        #1;
        check("frame_period", fd_period, DIGITS * PRESCALE);
        @(negedge clk);
        check("frame_done_width", bus.frame_done, 1'b0);
        // Tear-free: a load inside the digit-2 slot must wait for the next frame.
        push_frame(16'h12AF, 4'b0010);
        check_slot(BLANK_CYCLES - 1);
        check_slot(BLANK_CYCLES);
        do_load(16'h0000, 4'h0);
        push_frame(16'h0000, 4'h0);
        check_slot(BLANK_CYCLES - 1);
        check_slot(BLANK_CYCLES);
        repeat (4) check_slot(BLANK_CYCLES);
        // Disable while digit 1 is lit.
        exp_q.push_back(exp_slot(16'h0000, 4'h0, 0));
        check_slot(BLANK_CYCLES);
        repeat (BLANK_CYCLES) @(negedge clk);
        check("d1_lit", bus.an, 4'hD);
        fd_snap = fd_count;
        bus.enable = 1'b0;
        @(negedge clk);
        check("dis_an", bus.an, 4'hF);
        check("dis_seg", bus.seg, 7'h7F);
        check("dis_dp_out", bus.dp_out, 1'b1);
        check("dis_frame_done", bus.frame_done, 1'b0);
        repeat (4) @(negedge clk);
        check("dis_an_hold", bus.an, 4'hF);
        check("dis_no_frame_done", fd_count, fd_snap);
        // Restart from digit 0 with a value that has leading zeros.
        do_load(16'h0030, 4'h0);
        bus.enable = 1'b1;
        push_frame(16'h0030, 4'h0);
        check_slot(1 + BLANK_CYCLES);
        repeat (3) check_slot(BLANK_CYCLES);
        // Load on the frame_done cycle lands in the frame that follows.
        check("frame_done_boundary", bus.frame_done, 1'b1);
        do_load(16'h5555, 4'h0);
        push_frame(16'h5555, 4'h0);
        check_slot(BLANK_CYCLES - 1);
        repeat (3) check_slot(BLANK_CYCLES);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
